adc_seq_avg: RTL and testbench
==============================

Name: adc_seq_avg

Overview:
Parametrised sequencer and averager that drives the MAX10 modular ADC Avalon-ST command/response interface. It sweeps a programmable list of up to NUM_CH ADC channels and accumulates 2^AVG_LOG2 conversions per channel. It then emits one averaged 12-bit result per channel on a valid/ready stream to the trigger/readout logic. It replaces hand-issued single commands with free-running or single-shot sweeps.

Parameters:
NUM_CH, 4, number of list entries per sweep (1..8)
CH_W, 5, ADC channel field width (matches command_channel)
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of the number of sweeps averaged (0..4)

Ports:
clock_clk  in  1  system clock; also the ADC core clock
reset_sink_reset_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = sweep; sampled only in IDLE
single  in  1  1 = one averaged sweep set then IDLE; 0 = continuous
ch_list  in  NUM_CH*CH_W  entry i at bits [i*CH_W +: CH_W]; static while busy
command_valid  out  1  to ADC core
command_channel  out  CH_W  channel being requested
command_startofpacket  out  1  high on list entry 0
command_endofpacket  out  1  high on list entry NUM_CH-1
command_ready  in  1  from ADC core
response_valid  in  1  from ADC core
response_channel  in  CH_W  from ADC core
response_data  in  DATA_W  from ADC core
out_valid  out  1  averaged result available
out_ready  in  1  consumer accepts
out_index  out  3  list index of result
out_data  out  DATA_W  averaged value
busy  out  1  FSM not in IDLE
err_ch  out  1  sticky: response_channel mismatched the request; cleared on entering CMD from IDLE

Behaviour:
- Reset: all outputs 0, FSM = IDLE, accumulators 0, indices 0.
- FSM states: IDLE, CMD, RESP, EMIT.
- IDLE: if run=1, clear accumulators, sweep count and index, clear err_ch, go to CMD.
- CMD: command_valid=1, command_channel=ch_list[idx], sop=(idx==0), eop=(idx==NUM_CH-1).
  - Transfer when command_valid & command_ready; then go to RESP.
  - command_valid is held, and channel/sop/eop are stable, until the transfer.
- RESP: wait for response_valid; at most one command is outstanding.
  - On response: acc[idx] += response_data, zero-extended; acc width = DATA_W+AVG_LOG2, so no overflow is possible.
  - If response_channel != requested channel, set err_ch; the sample is still accumulated.
  - Then advance: idx++ → CMD.
  - At idx==NUM_CH-1: idx=0, sweep++. If sweep wraps from 2^AVG_LOG2-1 → EMIT, else → CMD.
  - A response_valid arriving outside RESP is ignored.
- EMIT: out_valid=1, out_index=eidx, out_data=acc[eidx]>>AVG_LOG2 (truncating; AVG_LOG2=0 passes raw).
  - Output fields are registered and stable while out_valid & !out_ready.
  - On accept: eidx++. After the entry NUM_CH-1 accept:
    - continuous and run=1 → clear accumulators and go to CMD (zero-cycle turnaround);
    - otherwise → IDLE.
- run is deasserted mid-sweep: the current sweep set completes and is emitted, then IDLE. No partial results are ever emitted.
- Reset asserted mid-operation: immediate return to IDLE; command_valid and out_valid drop asynchronously.
- Minimum latency from CMD entry to first out_valid = NUM_CH*2^AVG_LOG2*(2+ADC latency) cycles.
- busy = (state != IDLE).

Optional Feature:
ADC_SEQ_MINMAX_EN
- Defined: adds out_min and out_max outputs (DATA_W each, reset 0) plus per-channel min/max registers.
  - min is initialised to all-ones and max to 0 at accumulator clear.
  - Both update on each accepted response.
  - out_min/out_max are presented alongside out_data in EMIT, under the same handshake.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- NUM_CH=4, AVG_LOG2=2, ch_list={3,2,1,0}, single=1, ADC model returns 100,104,108,112 on the 4 sweeps for every channel → 4 outputs, index 0..3, out_data=106 each; then busy=0.
- command_ready held low for 5 cycles → command_valid, command_channel and sop stay stable; exactly one command per entry; sop on ch0 and eop on ch3 only.
- out_ready low for 10 cycles during EMIT → out_valid and out_data held; no new commands are issued; all results arrive in order after release.
- ADC model returns response_channel=7 for a request on ch 2 → err_ch=1, stays set through EMIT, clears on the next run start.
- Continuous mode, run dropped mid-sweep 2 → the full set is still emitted, then IDLE; reset_sink_reset_n pulsed in RESP → all outputs 0 within the same cycle, restart clean.
- ADC_SEQ_MINMAX_EN defined with samples 90,110,100,100 → out_min=90, out_max=110, out_data=100.

Source files
------------

// File: rtl/adc_seq_avg.sv
// adc_seq_avg: MAX10 ADC sweep sequencer with per-entry averaging; define ADC_SEQ_MINMAX_EN to add out_min/out_max
module adc_seq_avg #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 5,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   clock_clk,
  input  logic                   reset_sink_reset_n,
  input  logic                   run,
  input  logic                   single,
  input  logic [NUM_CH*CH_W-1:0] ch_list,
  output logic                   command_valid,
  output logic [CH_W-1:0]        command_channel,
  output logic                   command_startofpacket,
  output logic                   command_endofpacket,
  input  logic                   command_ready,
  input  logic                   response_valid,
  input  logic [CH_W-1:0]        response_channel,
  input  logic [DATA_W-1:0]      response_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_index,
  output logic [DATA_W-1:0]      out_data,
`ifdef ADC_SEQ_MINMAX_EN
  output logic [DATA_W-1:0]      out_min,
  output logic [DATA_W-1:0]      out_max,
`endif
  output logic                   busy,
  output logic                   err_ch
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  typedef enum logic [1:0] {IDLE, CMD, RESP, EMIT} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, eidx_q, eidx_d;
  logic [4:0] sweep_q, sweep_d;
  logic err_q, err_d;
  logic [ACC_W-1:0] acc_q [8];
  logic [CH_W-1:0] req_ch;
  logic start, restart, clr, resp_fire, last_idx, last_sweep, last_e;
  assign req_ch     = ch_list[int'(idx_q)*CH_W +: CH_W];
  assign last_idx   = idx_q == 3'(NUM_CH - 1);
  assign last_sweep = sweep_q == 5'((1 << AVG_LOG2) - 1);
  assign last_e     = eidx_q == 3'(NUM_CH - 1);
  assign start      = state_q == IDLE && run;
  assign restart    = state_q == EMIT && out_ready && last_e && !single && run;
  assign clr        = start || restart;
  assign resp_fire  = state_q == RESP && response_valid;
  assign busy                  = state_q != IDLE;
  assign err_ch                = err_q;
  assign command_valid         = state_q == CMD;
  assign command_channel       = state_q == CMD ? req_ch : '0;
  assign command_startofpacket = state_q == CMD && idx_q == 3'd0;
  assign command_endofpacket   = state_q == CMD && last_idx;
  assign out_valid             = state_q == EMIT;
  assign out_index             = state_q == EMIT ? eidx_q : 3'd0;
  assign out_data              = state_q == EMIT ? DATA_W'(acc_q[eidx_q] >> AVG_LOG2) : '0;
  // next-state: sweep sequencing, one outstanding command, in-order emit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sweep_d = sweep_q;
    eidx_d  = eidx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = run ? CMD : IDLE;
      CMD:  state_d = command_ready ? RESP : CMD;
      RESP: if (response_valid) begin
        idx_d   = last_idx ? 3'd0 : idx_q + 3'd1;
        sweep_d = last_idx ? (last_sweep ? 5'd0 : sweep_q + 5'd1) : sweep_q;
        state_d = last_idx && last_sweep ? EMIT : CMD;
        err_d   = err_q || response_channel != req_ch;
      end
      EMIT: if (out_ready) begin
        eidx_d  = last_e ? 3'd0 : eidx_q + 3'd1;
        state_d = !last_e ? EMIT : (!single && run) ? CMD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      idx_d   = 3'd0;
      sweep_d = 5'd0;
      eidx_d  = 3'd0;
      err_d   = 1'b0;
    end
  end
  // control state registers
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      eidx_q  <= '0;
      sweep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end
  // per-entry accumulators, wide enough that 2^AVG_LOG2 samples never overflow
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (clr) acc_q[i] <= '0;
        else if (resp_fire && idx_q == 3'(i)) acc_q[i] <= acc_q[i] + ACC_W'(response_data);
    end
  end
`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0] min_q [8];
  logic [DATA_W-1:0] max_q [8];
  assign out_min = state_q == EMIT ? min_q[eidx_q] : '0;
  assign out_max = state_q == EMIT ? max_q[eidx_q] : '0;
  // per-entry extremes, seeded so the first sample always wins
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      for (int i = 0; i < 8; i++) begin
        min_q[i] <= '0;
        max_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++)
        if (clr) begin
          min_q[i] <= '1;
          max_q[i] <= '0;
        end else if (resp_fire && idx_q == 3'(i)) begin
          min_q[i] <= response_data < min_q[i] ? response_data : min_q[i];
          max_q[i] <= response_data > max_q[i] ? response_data : max_q[i];
        end
    end
  end
`endif
endmodule

// File: tb/tb_adc_seq_avg.sv
// tb_adc_seq_avg: randomized ADC/consumer model with averaged-result reference checks
module tb_adc_seq_avg;
  localparam int NUM_CH = 4, CH_W = 5, DATA_W = 12, AVG_LOG2 = 2, NS = 1 << AVG_LOG2;
  logic clk = 0, rst_n = 0, run = 0, single = 1;
  logic [NUM_CH*CH_W-1:0] ch_list = '0;
  logic command_valid, cmd_sop, cmd_eop;
  logic [CH_W-1:0] command_channel;
  logic command_ready = 0, response_valid = 0, out_ready = 0;
  logic [CH_W-1:0] response_channel = '0;
  logic [DATA_W-1:0] response_data = '0;
  logic out_valid, busy, err_ch;
  logic [2:0] out_index;
  logic [DATA_W-1:0] out_data;
`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0] out_min, out_max;
`endif

  adc_seq_avg #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .run(run), .single(single), .ch_list(ch_list),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(cmd_sop), .command_endofpacket(cmd_eop), .command_ready(command_ready),
    .response_valid(response_valid), .response_channel(response_channel), .response_data(response_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
`ifdef ADC_SEQ_MINMAX_EN
    .out_min(out_min), .out_max(out_max),
`endif
    .busy(busy), .err_ch(err_ch));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int samp [NS][NUM_CH];
  int chl [NUM_CH];
  bit block_cmd = 0, stray = 0;
  int ordy_mode = 1, bad_entry = -1, gen = 0;
  typedef struct {int ch; bit sop; bit eop;} cmd_t;
  typedef struct {int idx; int data; int mn; int mx;} out_t;
  cmd_t cmdq[$];
  out_t outq[$];
  int hs = 0, last_gen = 0, cnt = 0, pch = 0, pdata = 0, e_m = 0;
  bit pend = 0;

  // ADC core and consumer model: one response 1..3 cycles after each accepted command
  always @(negedge clk) begin
    if (gen != last_gen) begin
      last_gen = gen;
      hs = 0;
      cmdq.delete();
      outq.delete();
    end
    if (!rst_n) begin
      pend = 0;
      response_valid = 0;
      command_ready = 0;
      out_ready = 0;
    end else begin
      response_valid = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          response_valid = 1;
          response_channel = CH_W'(pch);
          response_data = DATA_W'(pdata);
          pend = 0;
        end
      end else if (stray) begin
        response_valid = 1;
        response_channel = '1;
        response_data = '1;
      end
      command_ready = !block_cmd && ($urandom_range(0, 3) != 0);
      if (command_valid && command_ready) begin
        e_m = hs % NUM_CH;
        cmdq.push_back('{int'(command_channel), cmd_sop, cmd_eop});
        pch = (e_m == bad_entry) ? 7 : int'(command_channel);
        pdata = samp[(hs / NUM_CH) % NS][e_m];
        pend = 1;
        cnt = $urandom_range(1, 3);
        hs++;
      end
      out_ready = ordy_mode == 0 ? 1'b0 : ordy_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready)
`ifdef ADC_SEQ_MINMAX_EN
        outq.push_back('{int'(out_index), int'(out_data), int'(out_min), int'(out_max)});
`else
        outq.push_back('{int'(out_index), int'(out_data), 0, 0});
`endif
    end
  end

  function automatic int exp_avg(int e);
    int s = 0;
    for (int k = 0; k < NS; k++) s += samp[k][e];
    return s / NS;
  endfunction

  task automatic set_list;
    for (int e = 0; e < NUM_CH; e++) ch_list[e*CH_W +: CH_W] = CH_W'(chl[e]);
  endtask

  task automatic fill_basic;
    for (int e = 0; e < NUM_CH; e++) chl[e] = e;
    for (int s = 0; s < NS; s++) for (int e = 0; e < NUM_CH; e++) samp[s][e] = 100 + 4 * s;
    set_list();
  endtask

  task automatic fill_random;
    for (int e = 0; e < NUM_CH; e++) chl[e] = $urandom_range(0, 31);
    for (int s = 0; s < NS; s++) for (int e = 0; e < NUM_CH; e++) samp[s][e] = $urandom_range(0, 4095);
    set_list();
  endtask

  task automatic start_set(input bit sgl);
    @(negedge clk);
    gen++;
    single = sgl;
    run = 1;
    @(negedge clk);
    if (sgl) run = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    run = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (command_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", command_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (err_ch !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_ch); end
    checks++; if (out_data !== '0 || out_index !== 3'd0) begin failures++; $display("FAIL reset_out_fields got=%0d/%0d exp=0/0", out_data, out_index); end
    checks++; if (command_channel !== '0 || cmd_sop !== 1'b0 || cmd_eop !== 1'b0) begin failures++; $display("FAIL reset_cmd_fields got=%0d/%b/%b exp=0/0/0", command_channel, cmd_sop, cmd_eop); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    fill_basic();
    ordy_mode = 1;
    start_set(1);
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=busy exp=idle"); end
    checks++; if (outq.size() != NUM_CH) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", outq.size(), NUM_CH); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].idx != i || outq[i].data != 106) begin failures++; $display("FAIL basic_out%0d got=%0d/%0d exp=%0d/106", i, outq[i].idx, outq[i].data, i); end
    end
    checks++; if (cmdq.size() != NUM_CH * NS) begin failures++; $display("FAIL basic_cmds got=%0d exp=%0d", cmdq.size(), NUM_CH * NS); end
    for (int k = 0; k < cmdq.size(); k++) begin
      checks++; if (cmdq[k].ch != chl[k % NUM_CH] || cmdq[k].sop != (k % NUM_CH == 0) || cmdq[k].eop != (k % NUM_CH == NUM_CH - 1)) begin failures++; $display("FAIL basic_cmd%0d got=%0d/%b/%b exp=%0d/%b/%b", k, cmdq[k].ch, cmdq[k].sop, cmdq[k].eop, chl[k % NUM_CH], k % NUM_CH == 0, k % NUM_CH == NUM_CH - 1); end
    end
    checks++; if (busy !== 1'b0 || err_ch !== 1'b0) begin failures++; $display("FAIL basic_end got=%b/%b exp=0/0", busy, err_ch); end
  endtask

  task automatic test_random;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      ordy_mode = 2;
      start_set(1);
      wait_idle(3000, ok);
      checks++; if (!ok || outq.size() != NUM_CH) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, outq.size(), NUM_CH); end
      for (int i = 0; i < outq.size(); i++) begin
        checks++; if (outq[i].idx != i || outq[i].data != exp_avg(i)) begin failures++; $display("FAIL rand%0d_out%0d got=%0d/%0d exp=%0d/%0d", r, i, outq[i].idx, outq[i].data, i, exp_avg(i)); end
      end
      for (int k = 0; k < cmdq.size(); k++) begin
        checks++; if (cmdq[k].ch != chl[k % NUM_CH]) begin failures++; $display("FAIL rand%0d_cmd%0d got=%0d exp=%0d", r, k, cmdq[k].ch, chl[k % NUM_CH]); end
      end
    end
  endtask

  task automatic test_cmd_stall;
    bit ok, seen;
    fill_random();
    ordy_mode = 1;
    block_cmd = 1;
    start_set(1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (command_valid) seen = 1; else @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL stall_cmd_seen got=0 exp=1"); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (command_valid !== 1'b1 || command_channel !== CH_W'(chl[0]) || cmd_sop !== 1'b1 || cmd_eop !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b/%0d/%b/%b exp=1/%0d/1/0", command_valid, command_channel, cmd_sop, cmd_eop, chl[0]); end
    end
    checks++; if (cmdq.size() != 0) begin failures++; $display("FAIL stall_no_xfer got=%0d exp=0", cmdq.size()); end
    block_cmd = 0;
    wait_idle(3000, ok);
    checks++; if (!ok || cmdq.size() != NUM_CH * NS) begin failures++; $display("FAIL stall_cmds got=%0d exp=%0d", cmdq.size(), NUM_CH * NS); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].data != exp_avg(i)) begin failures++; $display("FAIL stall_out%0d got=%0d exp=%0d", i, outq[i].data, exp_avg(i)); end
    end
  endtask

  task automatic test_out_stall;
    bit ok, seen;
    fill_random();
    ordy_mode = 0;
    start_set(1);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (!seen || out_index !== 3'd0 || out_data !== DATA_W'(exp_avg(0))) begin failures++; $display("FAIL ostall_first got=%0d/%0d exp=0/%0d", out_index, out_data, exp_avg(0)); end
    stray = 1;
    repeat (10) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_index !== 3'd0 || out_data !== DATA_W'(exp_avg(0)) || command_valid !== 1'b0) begin failures++; $display("FAIL ostall_hold got=%b/%0d/%0d/%b exp=1/0/%0d/0", out_valid, out_index, out_data, command_valid, exp_avg(0)); end
    end
    stray = 0;
    ordy_mode = 1;
    wait_idle(200, ok);
    checks++; if (!ok || outq.size() != NUM_CH) begin failures++; $display("FAIL ostall_count got=%0d exp=%0d", outq.size(), NUM_CH); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].idx != i || outq[i].data != exp_avg(i)) begin failures++; $display("FAIL ostall_out%0d got=%0d/%0d exp=%0d/%0d", i, outq[i].idx, outq[i].data, i, exp_avg(i)); end
    end
  endtask

  task automatic test_err;
    bit ok, seen;
    fill_basic();
    ordy_mode = 1;
    bad_entry = 2;
    start_set(1);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (!seen || err_ch !== 1'b1) begin failures++; $display("FAIL err_in_emit got=%b exp=1", err_ch); end
    wait_idle(200, ok);
    checks++; if (err_ch !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_ch); end
    checks++; if (outq.size() != NUM_CH || outq[2].data != 106) begin failures++; $display("FAIL err_still_acc got=%0d exp=106", outq.size() > 2 ? outq[2].data : -1); end
    bad_entry = -1;
    start_set(1);
    checks++; if (err_ch !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_ch); end
    wait_idle(2000, ok);
    checks++; if (!ok || err_ch !== 1'b0) begin failures++; $display("FAIL err_clean_run got=%b exp=0", err_ch); end
  endtask

  task automatic test_continuous;
    bit ok;
    fill_random();
    ordy_mode = 2;
    start_set(0);
    for (int i = 0; i < 4000 && hs < NUM_CH * NS + NUM_CH + 2; i++) @(negedge clk);
    run = 0;
    wait_idle(4000, ok);
    checks++; if (!ok || outq.size() != 2 * NUM_CH) begin failures++; $display("FAIL cont_count got=%0d exp=%0d", outq.size(), 2 * NUM_CH); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].idx != i % NUM_CH || outq[i].data != exp_avg(i % NUM_CH)) begin failures++; $display("FAIL cont_out%0d got=%0d/%0d exp=%0d/%0d", i, outq[i].idx, outq[i].data, i % NUM_CH, exp_avg(i % NUM_CH)); end
    end
    checks++; if (cmdq.size() != 2 * NUM_CH * NS) begin failures++; $display("FAIL cont_cmds got=%0d exp=%0d", cmdq.size(), 2 * NUM_CH * NS); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    fill_basic();
    ordy_mode = 1;
    start_set(1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy && !command_valid) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_resp_seen got=0 exp=1"); end
    #2 rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0 || command_valid !== 1'b0 || out_valid !== 1'b0 || err_ch !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL rmid_async got=%b/%b/%b/%b exp=0/0/0/0", busy, command_valid, out_valid, err_ch); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start_set(1);
    wait_idle(2000, ok);
    checks++; if (!ok || outq.size() != NUM_CH || cmdq.size() != NUM_CH * NS) begin failures++; $display("FAIL rmid_restart got=%0d/%0d exp=%0d/%0d", outq.size(), cmdq.size(), NUM_CH, NUM_CH * NS); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].idx != i || outq[i].data != 106) begin failures++; $display("FAIL rmid_out%0d got=%0d/%0d exp=%0d/106", i, outq[i].idx, outq[i].data, i); end
    end
  endtask

`ifdef ADC_SEQ_MINMAX_EN
  task automatic test_minmax;
    bit ok;
    int pat [NS];
    pat = '{90, 110, 100, 100};
    fill_basic();
    for (int s = 0; s < NS; s++) for (int e = 0; e < NUM_CH; e++) samp[s][e] = pat[s];
    ordy_mode = 2;
    start_set(1);
    wait_idle(2000, ok);
    checks++; if (!ok || outq.size() != NUM_CH) begin failures++; $display("FAIL mm_count got=%0d exp=%0d", outq.size(), NUM_CH); end
    for (int i = 0; i < outq.size(); i++) begin
      checks++; if (outq[i].data != 100 || outq[i].mn != 90 || outq[i].mx != 110) begin failures++; $display("FAIL mm_out%0d got=%0d/%0d/%0d exp=100/90/110", i, outq[i].data, outq[i].mn, outq[i].mx); end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_cmd_stall();
    test_out_stall();
    test_err();
    test_continuous();
    test_reset_mid();
`ifdef ADC_SEQ_MINMAX_EN
    test_minmax();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
